// File: rtl/maze_pkg.sv
// Shared types for the depth-first maze solver: move codes, FSM states and
// single-step neighbour arithmetic with a grid bounds check.
package maze_pkg;

  localparam int CW = 16;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    LEFT  = 2'b10,
    DOWN  = 2'b11
  } move_t;

  typedef enum logic [3:0] {
    IDLE, INIT, PROBE, CHECK, ADVANCE, BACK, DONE, FAIL, REPLAY
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ok;
  } step_t;

  // Codes are laid out so that the reverse move is the bitwise complement.
  function automatic move_t opposite(input move_t m);
    return move_t'(~m);
  endfunction

  function automatic step_t step(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                 input logic [CW-1:0] xmax, input logic [CW-1:0] ymax,
                                 input move_t m);
    step_t s;
    s.x  = x;
    s.y  = y;
    s.ok = 1'b0;
    case (m)
      UP:    begin s.ok = (y != '0);   s.y = y - CW'(1); end
      RIGHT: begin s.ok = (x != xmax); s.x = x + CW'(1); end
      LEFT:  begin s.ok = (x != '0);   s.x = x - CW'(1); end
      DOWN:  begin s.ok = (y != ymax); s.y = y + CW'(1); end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/move_stack.sv
// LIFO of 2-bit moves with a random-access read port so a found path can be replayed.
// Push/pop take effect on the clock edge; top and rdata are combinational reads.
module move_stack
  import maze_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int PW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  move_t         push_dat,
  input  logic [AW-1:0] raddr,
  output move_t         top,
  output move_t         rdata,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          full
);

  move_t         mem [DEPTH];
  logic [PW-1:0] sp;
  logic [AW-1:0] tidx;

  assign tidx  = AW'(sp - PW'(1));
  assign top   = mem[tidx];
  assign rdata = mem[raddr];
  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == PW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push && !full) mem[AW'(sp)] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)         sp <= '0;
    else if (push && !full) sp <= sp + PW'(1);
    else if (pop && !empty) sp <= sp - PW'(1);
  end

endmodule

// File: rtl/maze_solver_p.sv
// Depth-first maze solver: 2 cycles per in-bounds probe, 1 per advance/backtrack/init.
// Replay streams the path one move per cycle; move holds while move_ready is low.
module maze_solver_p
  import maze_pkg::*;
#(
  parameter int X_W   = 4,
  parameter int Y_W   = 4,
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           run,
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [X_W-1:0] goal_x,
  input  logic [Y_W-1:0] goal_y,
  input  logic           din,
  output logic [X_W-1:0] pose_x,
  output logic [Y_W-1:0] pose_y,
  output logic           rd,
  output logic           wr,
  output logic           dout,
  output logic           done,
  output logic           fail,
  output logic [1:0]     move,
  output logic           move_valid,
  input  logic           move_ready
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] XMAX = CW'((1 << X_W) - 1);
  localparam logic [CW-1:0] YMAX = CW'((1 << Y_W) - 1);

  state_t        state, nstate;
  logic [CW-1:0] cx, cy, gx, gy, px, py;
  logic [1:0]    dir;
  logic [PW-1:0] ridx, rnext;

  logic          stk_push, stk_pop, stk_clr, stk_empty, stk_full;
  move_t         stk_top, stk_rdata;
  logic [PW-1:0] stk_cnt;
  logic [AW-1:0] stk_raddr;

  step_t         par, nb;
  step_t         st [4];
  logic [CW-1:0] base_x, base_y;
  logic [2:0]    base_d, sd;
  logic          found, cur_goal, adv_goal;

  move_stack #(.DEPTH(DEPTH)) u_stk (
    .clk(clk), .rst(rst), .clr(stk_clr), .push(stk_push), .pop(stk_pop),
    .push_dat(move_t'(dir)), .raddr(stk_raddr), .top(stk_top), .rdata(stk_rdata),
    .count(stk_cnt), .empty(stk_empty), .full(stk_full)
  );

  assign pose_x   = px[X_W-1:0];
  assign pose_y   = py[Y_W-1:0];
  assign dout     = 1'b1;
  assign done     = (state == DONE) || (state == REPLAY);
  assign fail     = (state == FAIL);
  assign rnext    = ridx + PW'(1);
  assign cur_goal = (cx == gx) && (cy == gy);
  assign adv_goal = (px == gx) && (py == gy);

  // Pick the cell and first direction to scan from, then the first in-bounds
  // direction at or after it; out-of-grid directions cost no cycles.
  always_comb begin
    par    = step(cx, cy, XMAX, YMAX, opposite(stk_top));
    base_x = cx;
    base_y = cy;
    base_d = 3'd0;
    case (state)
      CHECK:   base_d = {1'b0, dir} + 3'd1;
      ADVANCE: begin base_x = px; base_y = py; end
      BACK: if (par.ok) begin
        base_x = par.x;
        base_y = par.y;
        base_d = {1'b0, stk_top} + 3'd1;
      end
      default: ;
    endcase
    sd = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      st[i] = step(base_x, base_y, XMAX, YMAX, move_t'(2'(i)));
      if (st[i].ok && (3'(i) >= base_d)) sd = 3'(i);
    end
    found = !sd[2];
    nb    = st[sd[1:0]];
  end

  always_comb begin
    nstate    = state;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    stk_raddr = '0;
    case (state)
      IDLE:  if (start) nstate = INIT;
      INIT: begin
        stk_clr = 1'b1;
        if (cur_goal) nstate = DONE;
        else          nstate = found ? PROBE : BACK;
      end
      PROBE: nstate = CHECK;
      CHECK: begin
        if (!din) nstate = ADVANCE;
        else      nstate = found ? PROBE : BACK;
      end
      ADVANCE: begin
        if (stk_full) nstate = FAIL;
        else begin
          stk_push = 1'b1;
          if (adv_goal) nstate = DONE;
          else          nstate = found ? PROBE : BACK;
        end
      end
      BACK: begin
        if (stk_empty) nstate = FAIL;
        else begin
          stk_pop = 1'b1;
          nstate  = found ? PROBE : BACK;
        end
      end
      DONE: begin
        if (start)    nstate = INIT;
        else if (run) nstate = REPLAY;
      end
      FAIL:  if (start) nstate = INIT;
      REPLAY: begin
        stk_raddr = AW'(rnext);
        if (stk_empty) nstate = DONE;
        else if (move_valid && move_ready && (rnext == stk_cnt)) nstate = DONE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      gx         <= '0;
      gy         <= '0;
      px         <= '0;
      py         <= '0;
      dir        <= '0;
      ridx       <= '0;
      rd         <= 1'b0;
      wr         <= 1'b0;
      move       <= '0;
      move_valid <= 1'b0;
    end else begin
      state <= nstate;
      rd    <= (nstate == PROBE);
      wr    <= 1'b0;
      if (nstate == INIT) begin
        cx <= CW'(start_x);
        cy <= CW'(start_y);
        gx <= CW'(goal_x);
        gy <= CW'(goal_y);
        px <= CW'(start_x);
        py <= CW'(start_y);
        wr <= 1'b1;
      end
      if (nstate == PROBE) begin
        px  <= nb.x;
        py  <= nb.y;
        dir <= sd[1:0];
      end
      // A blocked advance (stack full) must leave memory untouched.
      if (nstate == ADVANCE) wr <= !stk_full;
      if (state == ADVANCE && !stk_full) begin
        cx <= px;
        cy <= py;
      end
      if (state == BACK && !stk_empty) begin
        cx <= par.x;
        cy <= par.y;
      end
      if (state == DONE && nstate == REPLAY) begin
        ridx       <= '0;
        move       <= stk_rdata;
        move_valid <= !stk_empty;
      end
      if (state == REPLAY && move_valid && move_ready) begin
        ridx <= rnext;
        if (rnext == stk_cnt) move_valid <= 1'b0;
        else                  move       <= stk_rdata;
      end
    end
  end

endmodule

// File: tb/tb_maze_solver_p.sv
// Directed bench for maze_solver_p: behavioural maze memory, hand-derived cycle
// counts, write traces and replay streams.
module tb_maze_solver_p;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst, start, run, move_ready, start4, clr;
  logic [3:0] start_x, start_y, goal_x, goal_y;
  logic din, din4;
  logic [3:0] pose_x, pose_y, p4x, p4y;
  logic rd, wr, dout, done, fail, move_valid;
  logic rd4, wr4, dout4, done4, fail4, mv4;
  logic [1:0] move, move4;

  logic [255:0] wall, vis, vis4;
  logic [7:0]   wlog [64];
  int           wn;
  logic [1:0]   got [16];
  int           got_n;
  int           checks = 0;
  int           errors = 0;
  int           n;

  always #5 clk = ~clk;

  maze_solver_p u_dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .din(din), .pose_x(pose_x), .pose_y(pose_y), .rd(rd), .wr(wr), .dout(dout),
    .done(done), .fail(fail), .move(move), .move_valid(move_valid),
    .move_ready(move_ready)
  );

  maze_solver_p #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .run(1'b0),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .din(din4), .pose_x(p4x), .pose_y(p4y), .rd(rd4), .wr(wr4), .dout(dout4),
    .done(done4), .fail(fail4), .move(move4), .move_valid(mv4),
    .move_ready(1'b1)
  );

  // Maze memory: static walls from the bench, visited marks from the DUT writes.
  assign din  = wall[{pose_y, pose_x}] | vis[{pose_y, pose_x}];
  assign din4 = wall[{p4y, p4x}] | vis4[{p4y, p4x}];

  always @(posedge clk) begin
    if (clr) begin
      vis  <= '0;
      vis4 <= '0;
      wn   <= 0;
    end else begin
      if (wr) begin
        vis[{pose_y, pose_x}] <= dout;
        if (wn < 64) wlog[wn] <= {pose_y, pose_x};
        wn <= wn + 1;
      end
      if (wr4) vis4[{p4y, p4x}] <= dout4;
    end
  end

  function automatic logic [7:0] ix(input int x, input int y);
    return 8'(y * 16 + x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_vis();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic launch(input int sx, input int sy, input int gx, input int gy);
    @(negedge clk);
    start_x = 4'(sx); start_y = 4'(sy);
    goal_x  = 4'(gx); goal_y  = 4'(gy);
    start   = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(done || fail) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic replay(input int budget);
    for (int i = 0; i < 16; i++) got[i] = 2'b00;
    got_n      = 0;
    move_ready = 1'b1;
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    for (int i = 0; i < budget && move_valid; i++) begin
      if (got_n < 16) got[got_n] = move;
      got_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; run = 1'b0; move_ready = 1'b0; start4 = 1'b0;
    clr = 1'b0; wall = '0;
    start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {rd, wr, dout, done, fail, move_valid, move, pose_x, pose_y}, 32'h2000);
    chk("reset_state", 32'(u_dut.state), 32'(IDLE));
    rst = 1'b0;
    clear_vis();

    // Free maze, straight run of three rights.
    launch(0, 0, 3, 0);
    chk("t1_init_wr", {wr, rd, pose_x, pose_y}, 32'h200);
    wait_end(200, n);
    chk("t1_cycles", n, 10);
    chk("t1_done_fail", {done, fail}, 32'h2);
    replay(20);
    chk("t1_len", got_n, 3);
    for (int i = 0; i < 3; i++) chk("t1_move", got[i], 32'h1);
    chk("t1_back_done", {done, move_valid}, 32'h2);

    // start == goal from DONE: stack is cleared, empty replay.
    launch(7, 7, 7, 7);
    wait_end(50, n);
    chk("teq_cycles", n, 1);
    replay(20);
    chk("teq_len", got_n, 0);
    chk("teq_replay_state", 32'(u_dut.state), 32'(REPLAY));
    @(negedge clk);
    chk("teq_back_done", 32'(u_dut.state), 32'(DONE));

    // Column x=1 walled: path straight down.
    wall = '0;
    for (int y = 0; y < 16; y++) wall[ix(1, y)] = 1'b1;
    clear_vis();
    launch(0, 0, 0, 3);
    wait_end(200, n);
    chk("t2_cycles", n, 20);
    chk("t2_wr_count", wn, 4);
    for (int i = 0; i < 4; i++) chk("t2_wr_addr", wlog[i], 32'(ix(0, i)));
    replay(20);
    chk("t2_len", got_n, 3);
    for (int i = 0; i < 3; i++) chk("t2_move", got[i], 32'h3);

    // Corridor with a dead end at (3,0): one backtrack.
    wall = '1;
    wall[ix(0, 0)] = 1'b0; wall[ix(1, 0)] = 1'b0; wall[ix(2, 0)] = 1'b0;
    wall[ix(3, 0)] = 1'b0; wall[ix(2, 1)] = 1'b0; wall[ix(2, 2)] = 1'b0;
    clear_vis();
    launch(0, 0, 2, 2);
    wait_end(300, n);
    chk("t3_cycles", n, 31);
    chk("t3_wr_count", wn, 6);
    chk("t3_deadend_marked", vis[ix(3, 0)], 32'h1);
    replay(20);
    chk("t3_len", got_n, 4);
    chk("t3_moves", {got[0], got[1], got[2], got[3]}, 32'h5F);

    // Stalled replay: move_ready 1,0,0,1.
    @(negedge clk) begin run = 1'b1; move_ready = 1'b1; end
    @(negedge clk) run = 1'b0;
    chk("st_first", {move_valid, move}, 32'h5);
    @(negedge clk) move_ready = 1'b0;
    chk("st_second", {move_valid, move}, 32'h5);
    @(negedge clk);
    chk("st_hold1", {move_valid, move}, 32'h5);
    @(negedge clk) move_ready = 1'b1;
    chk("st_hold2", {move_valid, move}, 32'h5);
    @(negedge clk);
    chk("st_third", {move_valid, move}, 32'h7);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {rd, wr, dout, done, fail, move_valid, move, pose_x, pose_y}, 32'h2000);
    chk("rst_state", 32'(u_dut.state), 32'(IDLE));
    rst = 1'b0;

    // Goal enclosed: only (0,0) and (1,0) are open.
    wall = '1;
    wall[ix(0, 0)] = 1'b0; wall[ix(1, 0)] = 1'b0;
    clear_vis();
    launch(0, 0, 3, 3);
    wait_end(200, n);
    chk("t4_cycles", n, 14);
    chk("t4_done_fail", {done, fail}, 32'h1);
    chk("t4_stack_empty", u_dut.u_stk.empty, 32'h1);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    chk("t4_run_ignored", {fail, move_valid}, 32'h2);

    // DEPTH=4 instance on a free maze: the fifth advance hits a full stack.
    wall = '0;
    clear_vis();
    @(negedge clk);
    start_x = 4'd0; start_y = 4'd0; goal_x = 4'd6; goal_y = 4'd0;
    start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    n = 0;
    while (!(done4 || fail4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_cycles", n, 16);
    chk("t5_done_fail", {done4, fail4}, 32'h1);
    chk("t5_last_cell", vis4[ix(4, 0)], 32'h1);
    chk("t5_no_write", vis4[ix(5, 0)], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
